// File: rtl/addsub_serial_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state encoding,
// result-flag bit positions and the single-bit full-adder helper.
package addsub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int NFLAGS = 3;

    // Returns {carry_out, sum} of a + b + ci.
    function automatic logic [1:0] full_adder(input logic a, input logic b, input logic ci);
        logic [1:0] r;
        r[0] = a ^ b ^ ci;
        r[1] = (a & b) | (ci & (a ^ b));
        return r;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice built from chained full adders; also
// exposes the carry into its top bit for signed-overflow detection.
module addsub_digit
    import addsub_serial_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] s,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [DIGIT-1:0] sum_s;
    logic             carry_s;
    logic             msb_in_s;
    logic [1:0]       fa_s;

    // Ripple the carry through the slice, remembering the carry entering the top bit.
    always_comb begin
        sum_s    = {DIGIT{1'b0}};
        carry_s  = c_in;
        msb_in_s = c_in;
        fa_s     = 2'b00;
        for (int i = 0; i < DIGIT; i++) begin
            fa_s     = full_adder(a[i], b[i], carry_s);
            sum_s[i] = fa_s[0];
            msb_in_s = carry_s;
            carry_s  = fa_s[1];
        end
    end

    assign s        = sum_s;
    assign c_out    = carry_s;
    assign c_msb_in = msb_in_s;

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes.
// Optional saturation on signed overflow is built when ADDSUB_SAT_EN is defined.
module addsub_serial
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT (1..WIDTH)");
    end

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   x_r;
    logic [WIDTH-1:0]   y_r;
    logic               carry_r;
    logic [WIDTH-1:0]   s_r;
    logic [NFLAGS-1:0]  flags_r;
    logic               out_valid_r;

    logic               accept_s;
    logic               last_s;
    logic [31:0]        base_s;
    logic [DIGIT-1:0]   dig_a_s;
    logic [DIGIT-1:0]   dig_b_s;
    logic [DIGIT-1:0]   dig_sum_s;
    logic               dig_cout_s;
    logic               dig_msb_in_s;
    logic [WIDTH-1:0]   res_s;
    logic [WIDTH-1:0]   fin_s;
    logic               ovf_s;

    assign in_ready = (state_r == IDLE) && !rst;
    assign base_s   = 32'(cnt_r) * 32'(DIGIT);
    assign dig_a_s  = x_r[base_s +: DIGIT];
    assign dig_b_s  = y_r[base_s +: DIGIT];
    assign ovf_s    = dig_msb_in_s ^ dig_cout_s;

    addsub_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a        (dig_a_s),
        .b        (dig_b_s),
        .c_in     (carry_r),
        .s        (dig_sum_s),
        .c_out    (dig_cout_s),
        .c_msb_in (dig_msb_in_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic with accept and final-digit strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_s    = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_DIG) begin
                    last_s      = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Merge the current digit into the result word and apply optional saturation.
    always_comb begin
        res_s                   = s_r;
        res_s[base_s +: DIGIT]  = dig_sum_s;
        fin_s                   = res_s;
`ifdef ADDSUB_SAT_EN
        if (ovf_s) begin
            // Overflow direction follows the sign of the latched x operand.
            fin_s = x_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            fin_s = res_s;
        end
`endif
    end

    // Operand latch, digit datapath, result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r         <= {WIDTH{1'b0}};
            y_r         <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            s_r         <= {WIDTH{1'b0}};
            flags_r     <= {NFLAGS{1'b0}};
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            x_r     <= x;
            y_r     <= y ^ {WIDTH{sub}};
            carry_r <= sub;
            cnt_r   <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            carry_r <= dig_cout_s;
            cnt_r   <= cnt_r + CW'(1'b1);
            if (last_s) begin
                s_r             <= fin_s;
                flags_r[FLAG_C] <= dig_cout_s;
                flags_r[FLAG_V] <= ovf_s;
                flags_r[FLAG_Z] <= (fin_s == {WIDTH{1'b0}});
                out_valid_r     <= 1'b1;
            end else begin
                s_r <= res_s;
            end
        end else if (state_r == DONE && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign s         = s_r;
    assign c_out     = flags_r[FLAG_C];
    assign ovf       = flags_r[FLAG_V];
    assign zero      = flags_r[FLAG_Z];
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=16, DIGIT=4): directed spec
// vectors, handshake/hold/reset-abort scenarios and random ops vs. an arithmetic model.
module tb_addsub_serial;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             sub;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;
    logic             zero;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] got_s;

    addsub_serial #(
        .WIDTH(WIDTH),
        .DIGIT(DIGIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the operand values, not a digit walk.
    task automatic model(input logic [15:0] xa, input logic [15:0] ya, input logic sa,
                         output logic [15:0] es, output logic ec, output logic ev, output logic ez);
        int sx, sy, exact;
        int ux, uy;
        ux = int'(xa);
        uy = int'(ya);
        sx = int'($signed(xa));
        sy = int'($signed(ya));
        exact = sa ? (sx - sy) : (sx + sy);
        es = sa ? (xa - ya) : (xa + ya);
        ec = sa ? (ux >= uy) : ((ux + uy) > 65535);
        ev = (exact > 32767) || (exact < -32768);
`ifdef ADDSUB_SAT_EN
        if (ev) es = xa[15] ? 16'h8000 : 16'h7FFF;
`endif
        ez = (es == 16'h0000);
    endtask

    task automatic run_op(input logic [15:0] xa, input logic [15:0] ya, input logic sa,
                          input int hold, input string tag);
        logic [15:0] es;
        logic ec, ev, ez;
        int k;
        model(xa, ya, sa, es, ec, ev, ez);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        x = xa;
        y = ya;
        sub = sa;
        @(posedge clk);
        @(negedge clk);
        // Garbage operands with in_valid held high must not disturb the op.
        x = ~xa;
        y = ya ^ 16'h5A5A;
        sub = ~sa;
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(NDIG));
        got_s = s;
        check({tag, "_s"}, 32'(s), 32'(es));
        check({tag, "_flags"}, {29'd0, c_out, ovf, zero}, {29'd0, ec, ev, ez});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold"}, {13'd0, out_valid, in_ready, c_out, ovf, zero, s},
                  {13'd0, 1'b1, 1'b0, ec, ev, ez, es});
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_release"}, {14'd0, out_valid, in_ready, s}, {14'd0, 1'b0, 1'b1, es});
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sub = 1'b0;
        x = 16'h0000;
        y = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_state", {12'd0, out_valid, c_out, ovf, zero, s}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        run_op(16'h1234, 16'h0FCC, 1'b0, 0, "add_basic");
        check("add_basic_const", 32'(got_s), 32'h2200);
        run_op(16'h0005, 16'h0007, 1'b1, 0, "sub_borrow");
        check("sub_borrow_const", 32'(got_s), 32'hFFFE);
        run_op(16'h1234, 16'h1234, 1'b1, 0, "sub_zero");
        check("sub_zero_const", 32'(got_s), 32'h0000);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, "add_ovf");
`ifdef ADDSUB_SAT_EN
        check("add_ovf_const", 32'(got_s), 32'h7FFF);
`else
        check("add_ovf_const", 32'(got_s), 32'h8000);
`endif
        run_op(16'h8000, 16'h0001, 1'b1, 0, "sub_ovf");
`ifdef ADDSUB_SAT_EN
        check("sub_ovf_const", 32'(got_s), 32'h8000);
`else
        check("sub_ovf_const", 32'(got_s), 32'h7FFF);
`endif
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, "add_carry_zero");
        run_op(16'h8000, 16'h8000, 1'b0, 0, "add_neg_ovf");
        run_op(16'hA5A5, 16'h3C3C, 1'b1, 5, "hold5");
        run_op(16'h0042, 16'h0017, 1'b0, 0, "after_hold");

        // Abort mid-RUN with a synchronous reset pulse.
        @(negedge clk);
        in_valid = 1'b1;
        x = 16'h7777;
        y = 16'h1111;
        sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready_in_rst", 32'(in_ready), 32'd0);
        check("abort_state", {12'd0, out_valid, c_out, ovf, zero, s}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        run_op(16'h1357, 16'h2468, 1'b1, 0, "after_abort");

        for (int i = 0; i < 24; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
